// File: rtl/dmni_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmni_mem_arbiter
// Purpose  : Round-robin arbiter with burst locking that shares the single
//            DMNI scratchpad port (byte WE, 32-bit addr/data, 1-cycle read
//            latency) among N_REQ requesters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i / lock_i        per-requester request / keep-ownership flags
//   we_i/addr_i/data_i    packed per-requester access (index k at [k*W +: W])
//   gnt_o                 one-hot grant; the access happens in that cycle
//   rvalid_o / rdata_o    read return, one cycle after a read grant
//   mem_we_o/mem_addr_o/mem_data_o/mem_data_i   memory side
//   busy_o / owner_o      burst ownership status / current or last owner
// Optional build macro
//   DMNI_MEM_ARB_STATS_EN adds clr_stats_i and stall_cnt_o (saturating
//                         per-requester stall counters, STAT_W bits each)
// ============================================================================
module dmni_mem_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 16,
  parameter int STAT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
`ifdef DMNI_MEM_ARB_STATS_EN
  input  logic                      clr_stats_i,
  output logic [STAT_W*N_REQ-1:0]   stall_cnt_o,
`endif
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [4*N_REQ-1:0]        we_i,
  input  logic [32*N_REQ-1:0]       addr_i,
  input  logic [32*N_REQ-1:0]       data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [31:0]               rdata_o,
  output logic [3:0]                mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_data_o,
  input  logic [31:0]               mem_data_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]  r_owner, w_owner_nxt;
  logic [7:0]        r_beat, w_beat_nxt;
  logic [N_REQ-1:0]  r_rvalid;
  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_start, w_pick;
  logic              w_found;
  logic [8:0]        w_beat_inc;

  // Index (base + off) reduced modulo N_REQ; works for non-power-of-two N_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin scan. While owned, the owner only reaches this scan when it
  // has dropped its request, so scanning from owner+1 gives the handover.
  always_comb begin
    w_start = (r_state == S_OWNED) ? rr_idx(r_owner, 1) : r_rr_ptr;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_i[rr_idx(w_start, i)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(w_start, i);
      end
    end
  end

  always_comb begin
    w_gnt        = '0;
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_beat_nxt   = r_beat;
    w_beat_inc   = {1'b0, r_beat} + 9'd1;
    if (r_state == S_OWNED && req_i[r_owner]) begin
      w_gnt[r_owner] = 1'b1;
      if (!lock_i[r_owner] || w_beat_inc == 9'(MAX_BURST)) begin
        w_state_nxt  = S_IDLE;
        w_rr_ptr_nxt = rr_idx(r_owner, 1);
        w_beat_nxt   = '0;
      end else begin
        w_beat_nxt = w_beat_inc[7:0];
      end
    end else begin
      if (r_state == S_OWNED) begin
        w_state_nxt  = S_IDLE;
        w_rr_ptr_nxt = rr_idx(r_owner, 1);
        w_beat_nxt   = '0;
      end
      if (w_found) begin
        w_gnt[w_pick] = 1'b1;
        w_owner_nxt   = w_pick;
        if (lock_i[w_pick] && (MAX_BURST > 1)) begin
          w_state_nxt = S_OWNED;
          w_beat_nxt  = 8'd1;
        end else begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = rr_idx(w_pick, 1);
          w_beat_nxt   = '0;
        end
      end
    end
    // No memory access may be issued while reset is held.
    if (rst_i) w_gnt = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_beat   <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_beat   <= w_beat_nxt;
      for (int k = 0; k < N_REQ; k++)
        r_rvalid[k] <= w_gnt[k] & (we_i[k*4 +: 4] == 4'b0000);
    end
  end

  // Memory mux; grant is one-hot so at most one term is selected.
  always_comb begin
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        mem_we_o   = we_i[k*4 +: 4];
        mem_addr_o = addr_i[k*32 +: 32];
        mem_data_o = data_i[k*32 +: 32];
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = mem_data_i;
  assign busy_o   = (r_state == S_OWNED);
  assign owner_o  = r_owner;

`ifdef DMNI_MEM_ARB_STATS_EN
  for (genvar k = 0; k < N_REQ; k++) begin : g_stat
    logic [STAT_W-1:0] r_stall;
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_stats_i)
        r_stall <= '0;
      else if (req_i[k] && !w_gnt[k] && !(&r_stall))
        r_stall <= r_stall + STAT_W'(1);
    end
    assign stall_cnt_o[k*STAT_W +: STAT_W] = r_stall;
  end
`else
  logic w_unused_stat;
  assign w_unused_stat = (STAT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmni_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmni_mem_arbiter
// Purpose  : Self-checking bench for dmni_mem_arbiter against a cycle-level
//            behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmni_mem_arbiter;
  localparam int N     = 3;
  localparam int MB    = 16;
  localparam int SW    = 8;
  localparam int IW    = $clog2(N);
  localparam int BOUND = (N - 1) * MB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req, lock;
  logic [4*N-1:0]    we;
  logic [32*N-1:0]   addr, data;
  logic [31:0]       mem_rd;
  logic [N-1:0]      gnt, rvalid;
  logic [31:0]       rdata, mem_addr, mem_wdata;
  logic [3:0]        mem_we;
  logic              busy;
  logic [IW-1:0]     owner;
`ifdef DMNI_MEM_ARB_STATS_EN
  logic              clr;
  logic [SW*N-1:0]   stall;
`endif

  dmni_mem_arbiter #(.N_REQ(N), .MAX_BURST(MB), .STAT_W(SW)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef DMNI_MEM_ARB_STATS_EN
    .clr_stats_i(clr), .stall_cnt_o(stall),
`endif
    .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr), .data_i(data),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rd), .busy_o(busy), .owner_o(owner)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state: is someone holding the port, who, how many beats
  // they have had, where the round-robin scan starts, and pending read returns.
  int          m_owned, m_owner, m_beats, m_ptr;
  logic [N-1:0] m_rvalid;
  int          m_stall[N];

  // Expected / observed values for the cycle just executed.
  int           exp_gk;
  logic [N-1:0] exp_gnt, exp_rvalid, obs_gnt, obs_rvalid;
  logic [3:0]   exp_mwe, obs_mwe;
  logic [31:0]  exp_maddr, exp_mdata, obs_maddr, obs_mdata, obs_rdata, drv_rd;
  int           exp_busy, exp_owner;
  logic         obs_busy;
  logic [IW-1:0] obs_owner;
  int           exp_stall[N];
  int           obs_stall[N];

  function automatic int first_from(int start);
    for (int i = 0; i < N; i++)
      if (req[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  // One clock cycle: inputs are already applied; sample at the falling edge,
  // then let the model follow the rising edge.
  task automatic drive_cycle();
    int gk, n_owned, n_owner, n_beats, n_ptr;
    logic [N-1:0] n_rvalid;
    @(negedge clk);
    exp_busy   = m_owned;
    exp_owner  = m_owner;
    exp_rvalid = m_rvalid;
    for (int k = 0; k < N; k++) exp_stall[k] = m_stall[k];
    n_owned = m_owned; n_owner = m_owner; n_beats = m_beats; n_ptr = m_ptr;
    gk = -1;
    if (rst) begin
      n_owned = 0; n_owner = 0; n_beats = 0; n_ptr = 0;
    end else if (m_owned != 0 && req[m_owner]) begin
      gk = m_owner;
      if (!lock[m_owner] || m_beats + 1 == MB) begin
        n_owned = 0; n_ptr = (m_owner + 1) % N; n_beats = 0;
      end else begin
        n_beats = m_beats + 1;
      end
    end else begin
      if (m_owned != 0) begin
        n_owned = 0; n_ptr = (m_owner + 1) % N; n_beats = 0;
        gk = first_from((m_owner + 1) % N);
      end else begin
        gk = first_from(m_ptr);
      end
      if (gk >= 0) begin
        n_owner = gk;
        if (lock[gk] && MB > 1) begin n_owned = 1; n_beats = 1; end
        else begin n_owned = 0; n_ptr = (gk + 1) % N; n_beats = 0; end
      end
    end
    exp_gk = gk;
    exp_gnt = '0;
    n_rvalid = '0;
    exp_mwe = '0; exp_maddr = '0; exp_mdata = '0;
    if (gk >= 0) begin
      exp_gnt[gk] = 1'b1;
      exp_mwe   = we[gk*4 +: 4];
      exp_maddr = addr[gk*32 +: 32];
      exp_mdata = data[gk*32 +: 32];
      if (we[gk*4 +: 4] == 4'h0) n_rvalid[gk] = 1'b1;
    end
    drv_rd     = mem_rd;
    obs_gnt    = gnt;    obs_rvalid = rvalid; obs_rdata = rdata;
    obs_mwe    = mem_we; obs_maddr  = mem_addr; obs_mdata = mem_wdata;
    obs_busy   = busy;   obs_owner  = owner;
`ifdef DMNI_MEM_ARB_STATS_EN
    for (int k = 0; k < N; k++) obs_stall[k] = int'(stall[k*SW +: SW]);
`else
    for (int k = 0; k < N; k++) obs_stall[k] = 0;
`endif
    @(posedge clk);
    m_owned = n_owned; m_owner = n_owner; m_beats = n_beats; m_ptr = n_ptr;
    m_rvalid = n_rvalid;
    for (int k = 0; k < N; k++) begin
`ifdef DMNI_MEM_ARB_STATS_EN
      if (rst || clr) m_stall[k] = 0;
      else if (req[k] && gk != k && m_stall[k] < (1 << SW) - 1) m_stall[k]++;
`else
      m_stall[k] = 0;
`endif
    end
    #1;
  endtask

  task automatic set_req(int k, logic r, logic l, logic [3:0] w, logic [31:0] a);
    req[k] = r; lock[k] = l; we[k*4 +: 4] = w; addr[k*32 +: 32] = a;
    data[k*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; lock = '0; we = {N{4'hF}};
    for (int c = 0; c < 2; c++) begin
      drive_cycle();
      total++;
      if (obs_gnt !== '0 || obs_mwe !== 4'h0)
        begin bad++; $display("FAIL reset_gnt: gnt=%b mem_we=%h required 0/0", obs_gnt, obs_mwe); end
    end
    rst = 1'b0; req = '0;
    drive_cycle();
    total++;
    if (obs_busy !== 1'b0 || obs_rvalid !== '0 || obs_owner !== '0 || obs_gnt !== '0)
      begin bad++; $display("FAIL reset_state: busy=%b rvalid=%b owner=%0d gnt=%b required 0", obs_busy, obs_rvalid, obs_owner, obs_gnt); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 4'($urandom_range(1, 15)), $urandom);
      drive_cycle();
      total++;
      if (obs_gnt !== N'(1 << (i % N)) || obs_gnt !== exp_gnt)
        begin bad++; $display("FAIL rr_order beat %0d: gnt=%b required %b", i, obs_gnt, N'(1 << (i % N))); end
      total++;
      if ({obs_mwe, obs_maddr, obs_mdata} !== {exp_mwe, exp_maddr, exp_mdata})
        begin bad++; $display("FAIL rr_mux beat %0d: we=%h addr=%h data=%h required %h %h %h", i, obs_mwe, obs_maddr, obs_mdata, exp_mwe, exp_maddr, exp_mdata); end
    end
    req = '0;
  endtask

  task automatic test_read_return();
    logic [31:0] rd;
    set_req(1, 1'b1, 1'b0, 4'h0, 32'h100);
    drive_cycle();
    total++;
    if (obs_gnt !== 3'b010 || obs_maddr !== 32'h100 || obs_mwe !== 4'h0)
      begin bad++; $display("FAIL read_grant: gnt=%b addr=%h we=%h required 010 100 0", obs_gnt, obs_maddr, obs_mwe); end
    req = '0; rd = $urandom; mem_rd = rd;
    drive_cycle();
    total++;
    if (obs_rvalid !== 3'b010 || obs_rdata !== rd)
      begin bad++; $display("FAIL read_rvalid: rvalid=%b rdata=%h required 010 %h", obs_rvalid, obs_rdata, rd); end
    drive_cycle();
    total++;
    if (obs_rvalid !== 3'b000)
      begin bad++; $display("FAIL read_rvalid_clear: rvalid=%b required 000", obs_rvalid); end
  endtask

  task automatic test_burst();
    int beats0, cyc, idx;
    logic served2;
    int seq[$];
    int want[$];
    rst = 1'b1; req = '0; drive_cycle(); rst = 1'b0;
    beats0 = 0; served2 = 1'b0; cyc = 0;
    while ((beats0 < 20 || !served2) && cyc < 60) begin
      set_req(0, beats0 < 20, beats0 < 19, 4'hF, 32'h1000 + 32'(beats0 * 4));
      set_req(2, !served2, 1'b0, 4'h3, 32'h2000);
      drive_cycle();
      cyc++;
      total++;
      if (obs_gnt !== exp_gnt || obs_busy !== 1'(exp_busy))
        begin bad++; $display("FAIL burst_cycle %0d: gnt=%b busy=%b required %b %0d", cyc, obs_gnt, obs_busy, exp_gnt, exp_busy); end
      if (obs_gnt[0]) begin beats0++; seq.push_back(0); end
      if (obs_gnt[2]) begin served2 = 1'b1; seq.push_back(2); end
    end
    req = '0; lock = '0;
    for (int i = 0; i < 16; i++) want.push_back(0);
    want.push_back(2);
    for (int i = 0; i < 4; i++) want.push_back(0);
    total++;
    if (cyc >= 60 || seq.size() != want.size())
      begin bad++; $display("FAIL burst_length: grants=%0d cycles=%0d required %0d grants", seq.size(), cyc, want.size()); end
    else begin
      idx = -1;
      for (int i = 0; i < want.size(); i++) if (idx < 0 && seq[i] != want[i]) idx = i;
      total++;
      if (idx >= 0)
        begin bad++; $display("FAIL burst_sequence: grant %0d went to %0d required %0d", idx, seq[idx], want[idx]); end
    end
  endtask

  task automatic test_handover();
    rst = 1'b1; req = '0; drive_cycle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 1'b1, 4'hF, 32'h40 + 32'(i));
      drive_cycle();
    end
    set_req(0, 1'b0, 1'b0, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h1, 32'h3000);
    drive_cycle();
    total++;
    if (obs_gnt !== 3'b010 || obs_busy !== 1'b1 || obs_maddr !== 32'h3000)
      begin bad++; $display("FAIL handover: gnt=%b busy=%b addr=%h required 010 1 3000", obs_gnt, obs_busy, obs_maddr); end
    req = '0;
    drive_cycle();
    total++;
    if (obs_busy !== 1'b0 || obs_owner !== IW'(1))
      begin bad++; $display("FAIL handover_after: busy=%b owner=%0d required 0 1", obs_busy, obs_owner); end
  endtask

  task automatic test_reset_mid_burst();
    rst = 1'b1; req = '0; drive_cycle(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 1'b1, 4'hF, 32'h500 + 32'(i * 4));
      drive_cycle();
    end
    set_req(0, 1'b1, 1'b1, 4'h0, 32'h510);
    rst = 1'b1;
    drive_cycle();
    total++;
    if (obs_gnt !== '0 || obs_mwe !== 4'h0)
      begin bad++; $display("FAIL midrst_gnt: gnt=%b we=%h required 0 0", obs_gnt, obs_mwe); end
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 4'h0, 32'h600 + 32'(k));
    drive_cycle();
    total++;
    if (obs_busy !== 1'b0 || obs_rvalid !== '0 || obs_gnt !== 3'b001)
      begin bad++; $display("FAIL midrst_after: busy=%b rvalid=%b gnt=%b required 0 000 001", obs_busy, obs_rvalid, obs_gnt); end
    req = '0;
    drive_cycle();
  endtask

  task automatic test_random();
    int waitc[N];
    for (int k = 0; k < N; k++) waitc[k] = 0;
    obs_gnt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (obs_gnt[k] || !req[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          we[k*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
          addr[k*32 +: 32] = $urandom;
          data[k*32 +: 32] = $urandom;
        end
        lock[k] = ($urandom_range(0, 3) != 0);
      end
      mem_rd = $urandom;
      drive_cycle();
      total++;
      if (obs_gnt !== exp_gnt || {obs_mwe, obs_maddr, obs_mdata} !== {exp_mwe, exp_maddr, exp_mdata}
          || obs_rvalid !== exp_rvalid || obs_rdata !== drv_rd || obs_busy !== 1'(exp_busy)
          || obs_owner !== IW'(exp_owner))
        begin bad++; $display("FAIL random cycle %0d: gnt=%b rv=%b busy=%b own=%0d addr=%h required gnt=%b rv=%b busy=%0d own=%0d addr=%h",
                              c, obs_gnt, obs_rvalid, obs_busy, obs_owner, obs_maddr, exp_gnt, exp_rvalid, exp_busy, exp_owner, exp_maddr); end
      for (int k = 0; k < N; k++) begin
        if (obs_gnt[k]) begin
          total++;
          if (waitc[k] + 1 > BOUND)
            begin bad++; $display("FAIL starvation req %0d: waited %0d cycles, bound %0d", k, waitc[k] + 1, BOUND); end
          waitc[k] = 0;
        end else if (req[k]) begin
          waitc[k]++;
        end
      end
    end
    req = '0; lock = '0;
  endtask

`ifdef DMNI_MEM_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1; req = '0; clr = 1'b0; drive_cycle(); rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      set_req(0, 1'b1, 1'b1, 4'hF, 32'h0);
      set_req(2, 1'b1, 1'b0, 4'hF, 32'h8);
      drive_cycle();
    end
    drive_cycle();
    total++;
    if (obs_stall[2] != 7 || obs_stall[2] != exp_stall[2])
      begin bad++; $display("FAIL stats_wait7: stall2=%0d required 7", obs_stall[2]); end
    clr = 1'b1; drive_cycle(); clr = 1'b0;
    drive_cycle();
    total++;
    if (obs_stall[2] != exp_stall[2] || obs_stall[0] != 0)
      begin bad++; $display("FAIL stats_clear: stall2=%0d stall0=%0d required %0d 0", obs_stall[2], obs_stall[0], exp_stall[2]); end
    for (int c = 0; c < 320; c++) begin
      drive_cycle();
      for (int k = 0; k < N; k++) begin
        total++;
        if (obs_stall[k] != exp_stall[k])
          begin bad++; $display("FAIL stats_count req %0d cycle %0d: %0d required %0d", k, c, obs_stall[k], exp_stall[k]); end
      end
    end
    total++;
    if (obs_stall[2] != (1 << SW) - 1)
      begin bad++; $display("FAIL stats_saturate: stall2=%0d required %0d", obs_stall[2], (1 << SW) - 1); end
    req = '0; lock = '0;
  endtask
`endif

  initial begin
    m_owned = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_rvalid = '0;
    for (int k = 0; k < N; k++) m_stall[k] = 0;
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; data = '0; mem_rd = '0;
`ifdef DMNI_MEM_ARB_STATS_EN
    clr = 1'b0;
`endif
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_read_return();
    test_burst();
    test_handover();
    test_reset_mid_burst();
    test_random();
`ifdef DMNI_MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
